// File: rtl/seg7_bin_display.sv
// Converts a 16-bit binary value to five decimal digits with a shift-and-add-3 sequencer,
// then loads all five 7-segment outputs together so a partial result is never shown.
module seg7_bin_display #(
  parameter int ACTIVE_LOW    = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic [6:0]  seg_7_0,
  output logic [6:0]  seg_7_1,
  output logic [6:0]  seg_7_2,
  output logic [6:0]  seg_7_3,
  output logic [6:0]  seg_7_4
);

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  localparam logic [6:0] BLANK_PAT = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  state_t      state, state_nxt;
  logic [15:0] shift_q;
  logic [19:0] bcd_q;
  logic [19:0] bcd_adj;
  logic [4:0]  cnt_q;
  logic        accept;
  logic [6:0]  seg_nxt [5];

  // done is high in the first IDLE cycle after UPDATE, so a start there is dropped
  assign accept = (state == IDLE) && start && !done;

  function automatic logic [6:0] enc7(input logic [3:0] d);
    case (d)
      4'd0:    enc7 = 7'h3F;
      4'd1:    enc7 = 7'h06;
      4'd2:    enc7 = 7'h5B;
      4'd3:    enc7 = 7'h4F;
      4'd4:    enc7 = 7'h66;
      4'd5:    enc7 = 7'h6D;
      4'd6:    enc7 = 7'h7D;
      4'd7:    enc7 = 7'h07;
      4'd8:    enc7 = 7'h7F;
      4'd9:    enc7 = 7'h6F;
      default: enc7 = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CONVERT;
      CONVERT: if (cnt_q == 5'd15) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Walk from the most significant digit down; blanking stops at the first nonzero digit
  always_comb begin
    logic       lead_zero;
    logic [6:0] pat;
    seg_nxt   = '{default: '0};
    lead_zero = (BLANK_LEADING != 0);
    pat       = '0;
    for (int unsigned j = 0; j < 5; j++) begin
      lead_zero = lead_zero && (bcd_q[4*(4-j) +: 4] == 4'd0) && (j != 4);
      pat       = lead_zero ? 7'h00 : enc7(bcd_q[4*(4-j) +: 4]);
      seg_nxt[4-j] = (ACTIVE_LOW != 0) ? ~pat : pat;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      seg_7_0 <= BLANK_PAT;
      seg_7_1 <= BLANK_PAT;
      seg_7_2 <= BLANK_PAT;
      seg_7_3 <= BLANK_PAT;
      seg_7_4 <= BLANK_PAT;
    end else begin
      done <= (state == UPDATE);
      if (accept) begin
        shift_q <= value;
        bcd_q   <= '0;
        cnt_q   <= '0;
        busy    <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (state == CONVERT) begin
        {bcd_q, shift_q} <= {bcd_adj[18:0], shift_q, 1'b0};
        cnt_q            <= cnt_q + 5'd1;
      end
      if (state == UPDATE) begin
        seg_7_0 <= seg_nxt[0];
        seg_7_1 <= seg_nxt[1];
        seg_7_2 <= seg_nxt[2];
        seg_7_3 <= seg_nxt[3];
        seg_7_4 <= seg_nxt[4];
      end
    end
  end

endmodule

// File: tb/tb_seg7_bin_display.sv
// Directed bench for seg7_bin_display: three instances (default, no leading blanking,
// active-high) share stimulus; each task checks its own expected values inline.
module tb_seg7_bin_display;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] value;
  logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [6:0]  sa [5];
  logic [6:0]  sb [5];
  logic [6:0]  sc [5];
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  seg7_bin_display dut_a (
    .clk_clk(clk), .reset_reset_n(reset_n), .start(start), .value(value),
    .busy(busy_a), .done(done_a),
    .seg_7_0(sa[0]), .seg_7_1(sa[1]), .seg_7_2(sa[2]), .seg_7_3(sa[3]), .seg_7_4(sa[4])
  );

  seg7_bin_display #(.ACTIVE_LOW(1), .BLANK_LEADING(0)) dut_b (
    .clk_clk(clk), .reset_reset_n(reset_n), .start(start), .value(value),
    .busy(busy_b), .done(done_b),
    .seg_7_0(sb[0]), .seg_7_1(sb[1]), .seg_7_2(sb[2]), .seg_7_3(sb[3]), .seg_7_4(sb[4])
  );

  seg7_bin_display #(.ACTIVE_LOW(0), .BLANK_LEADING(1)) dut_c (
    .clk_clk(clk), .reset_reset_n(reset_n), .start(start), .value(value),
    .busy(busy_c), .done(done_c),
    .seg_7_0(sc[0]), .seg_7_1(sc[1]), .seg_7_2(sc[2]), .seg_7_3(sc[3]), .seg_7_4(sc[4])
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge and returns cycles from the accepting edge to done (-1 on timeout)
  task automatic start_and_wait(input logic [15:0] v, output int lat);
    value = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done_a) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start   = 1'b0;
    value   = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    checks++;
    if ({busy_a, done_a, busy_b, done_b, busy_c, done_c} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 000000", {busy_a, done_a, busy_b, done_b, busy_c, done_c});
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (sa[k] !== 7'h7F || sb[k] !== 7'h7F || sc[k] !== 7'h00) begin
        fails++;
        $display("FAIL reset_seg%0d: got a=%h b=%h c=%h expected a=7f b=7f c=00", k, sa[k], sb[k], sc[k]);
      end
    end
  endtask

  task automatic test_latency;
    int lat;
    logic busy_at_done;
    value = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      fails++;
      $display("FAIL busy_after_accept: got busy=%b done=%b expected busy=1 done=0", busy_a, done_a);
    end
    lat = -1;
    busy_at_done = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done_a) begin
        lat = i;
        busy_at_done = busy_a;
        break;
      end
    end
    checks++;
    if (lat != 17) begin
      fails++;
      $display("FAIL done_latency: got %0d expected 17", lat);
    end
    checks++;
    if (busy_at_done !== 1'b1) begin
      fails++;
      $display("FAIL busy_in_done_cycle: got %b expected 1", busy_at_done);
    end
    tick();
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      fails++;
      $display("FAIL after_done: got busy=%b done=%b expected busy=0 done=0", busy_a, done_a);
    end
  endtask

  task automatic test_patterns;
    logic [15:0] v  [5];
    logic [6:0]  ea [5][5];
    logic [6:0]  eb [5][5];
    logic [6:0]  ec [5][5];
    int lat;
    v = '{16'd0, 16'd65535, 16'd1234, 16'd10, 16'd1005};
    ea[0] = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    eb[0] = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    ec[0] = '{7'h3F, 7'h00, 7'h00, 7'h00, 7'h00};
    ea[1] = '{7'h12, 7'h30, 7'h12, 7'h12, 7'h02};
    eb[1] = '{7'h12, 7'h30, 7'h12, 7'h12, 7'h02};
    ec[1] = '{7'h6D, 7'h4F, 7'h6D, 7'h6D, 7'h7D};
    ea[2] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h7F};
    eb[2] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    ec[2] = '{7'h66, 7'h4F, 7'h5B, 7'h06, 7'h00};
    ea[3] = '{7'h40, 7'h79, 7'h7F, 7'h7F, 7'h7F};
    eb[3] = '{7'h40, 7'h79, 7'h40, 7'h40, 7'h40};
    ec[3] = '{7'h3F, 7'h06, 7'h00, 7'h00, 7'h00};
    ea[4] = '{7'h12, 7'h40, 7'h40, 7'h79, 7'h7F};
    eb[4] = '{7'h12, 7'h40, 7'h40, 7'h79, 7'h40};
    ec[4] = '{7'h6D, 7'h3F, 7'h3F, 7'h06, 7'h00};
    for (int t = 0; t < 5; t++) begin
      start_and_wait(v[t], lat);
      checks++;
      if (lat != 17) begin
        fails++;
        $display("FAIL latency_v%0d: got %0d expected 17", v[t], lat);
      end
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (sa[k] !== ea[t][k] || sb[k] !== eb[t][k] || sc[k] !== ec[t][k]) begin
          fails++;
          $display("FAIL pattern_v%0d_seg%0d: got a=%h b=%h c=%h expected a=%h b=%h c=%h",
                   v[t], k, sa[k], sb[k], sc[k], ea[t][k], eb[t][k], ec[t][k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    int first, ndone;
    logic busy18;
    value = 16'd1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    value = 16'd999;
    start = 1'b1;
    tick();
    start = 1'b0;
    first  = -1;
    ndone  = 0;
    busy18 = 1'bx;
    for (int i = 6; i <= 40; i++) begin
      tick();
      if (done_a) begin
        ndone++;
        if (first < 0) first = i;
      end
      if (i == 18) busy18 = busy_a;
    end
    checks++;
    if (first != 17 || ndone != 1) begin
      fails++;
      $display("FAIL b2b_done: got first=%0d count=%0d expected first=17 count=1", first, ndone);
    end
    checks++;
    if (busy18 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_busy_n18: got %b expected 0", busy18);
    end
    checks++;
    if ({sa[4], sa[3], sa[2], sa[1], sa[0]} !== {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}) begin
      fails++;
      $display("FAIL b2b_value: got %h %h %h %h %h expected 7f 79 24 30 19", sa[4], sa[3], sa[2], sa[1], sa[0]);
    end
  endtask

  task automatic test_start_on_done;
    int lat, ndone;
    start_and_wait(16'd10, lat);
    value = 16'd65535;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (lat != 17 || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL start_on_done: got lat=%0d busy=%b expected lat=17 busy=0", lat, busy_a);
    end
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_a) ndone++;
    end
    checks++;
    if (ndone != 0 || sa[0] !== 7'h40 || sa[1] !== 7'h79 || sa[2] !== 7'h7F) begin
      fails++;
      $display("FAIL hold_after_done: got dones=%0d seg0=%h seg1=%h seg2=%h expected 0 40 79 7f",
               ndone, sa[0], sa[1], sa[2]);
    end
  endtask

  task automatic test_reset_abort;
    int ndone, lat;
    value = 16'd1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || busy_c !== 1'b0) begin
      fails++;
      $display("FAIL abort_flags: got busy=%b done=%b busy_c=%b expected 0 0 0", busy_a, done_a, busy_c);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (sa[k] !== 7'h7F || sb[k] !== 7'h7F || sc[k] !== 7'h00) begin
        fails++;
        $display("FAIL abort_seg%0d: got a=%h b=%h c=%h expected a=7f b=7f c=00", k, sa[k], sb[k], sc[k]);
      end
    end
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_a || done_b || done_c) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d expected 0", ndone);
    end
    start_and_wait(16'd1005, lat);
    checks++;
    if (lat != 17 || sa[0] !== 7'h12 || sa[3] !== 7'h79) begin
      fails++;
      $display("FAIL after_abort: got lat=%0d seg0=%h seg3=%h expected 17 12 79", lat, sa[0], sa[3]);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    value   = '0;
    test_reset();
    test_latency();
    test_patterns();
    test_back_to_back();
    test_start_on_done();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
